// File: rtl/reg_xfer_seq_pkg.sv
// reg_xfer_seq_pkg: shared CPU definitions used by the register-transfer sequencer.
//   reg_id_t    : architectural register ids (A, X, Y, SP, P). The 3-bit encoding
//                 leaves room for out-of-range ids, which the sequencer rejects.
//   xfer_kind_t : MOV / INC / DEC.
//   BYTE        : architectural register width.
//   P_N_BIT / P_Z_BIT : bit positions of N and Z in the status register.
//   Helpers     : legality check, 8-bit ALU for the transfer, N/Z merge into P.
package reg_xfer_seq_pkg;

   localparam int unsigned BYTE    = 8;
   localparam int unsigned P_N_BIT = 7;
   localparam int unsigned P_Z_BIT = 1;

   typedef enum logic [2:0] {
      REG_A  = 3'd0,
      REG_X  = 3'd1,
      REG_Y  = 3'd2,
      REG_SP = 3'd3,
      REG_P  = 3'd4
   } reg_id_t;

   typedef enum logic [1:0] {
      XK_MOV = 2'd0,
      XK_INC = 2'd1,
      XK_DEC = 2'd2
   } xfer_kind_t;

   // P is never a transfer operand, ids above P do not exist, and INC/DEC
   // must name the same register on both sides. The unused kind encoding is
   // rejected too, so a corrupted decode never writes the register file.
   function automatic logic xfer_legal(input xfer_kind_t kind,
                                       input reg_id_t    src,
                                       input reg_id_t    dst);
      logic ok;
      ok = 1'b1;
      if (src >= REG_P || dst >= REG_P) ok = 1'b0;
      if (kind != XK_MOV && src != dst) ok = 1'b0;
      if (kind != XK_MOV && kind != XK_INC && kind != XK_DEC) ok = 1'b0;
      return ok;
   endfunction

   // Wraps modulo 256 by construction.
   function automatic logic [BYTE-1:0] xfer_alu(input xfer_kind_t      kind,
                                                input logic [BYTE-1:0] operand);
      logic [BYTE-1:0] res;
      unique case (kind)
         XK_INC:  res = operand + BYTE'(1);
         XK_DEC:  res = operand - BYTE'(1);
         default: res = operand;
      endcase
      return res;
   endfunction

   // Replace only N and Z in a status byte; every other P bit is preserved.
   function automatic logic [BYTE-1:0] p_with_nz(input logic [BYTE-1:0] p,
                                                 input logic [BYTE-1:0] res);
      logic [BYTE-1:0] q;
      q          = p;
      q[P_N_BIT] = res[BYTE-1];
      q[P_Z_BIT] = (res == '0);
      return q;
   endfunction

endpackage

// File: rtl/reg_xfer_seq.sv
// reg_xfer_seq: executes 6502 register-to-register transfers (TAX/TXA/TAY/TYA/
// TSX/TXS, INX/DEX/INY/DEY) against a single-port register file.
//
// Build option: define XFER_FLAGS_EN to add the FL_RD/FL_WR states that
// update P.N/P.Z after every legal op whose destination is not SP. Without it,
// P is never touched and every legal op completes in WR_DST.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   op_valid_i / op_ready_o  operation handshake from decode
//   op_kind_i, op_src_i, op_dst_i  operation fields
//   done_o                   one-cycle completion pulse
//   err_o                    one-cycle pulse with done_o for illegal ops
//   rf_addr_o, rf_we_o, rf_wdata_o  register-file port (data zero-extended)
//   rf_rdata_i               register-file read data, combinational from rf_addr_o
module reg_xfer_seq
   import reg_xfer_seq_pkg::*;
#(
   parameter int unsigned RF_DW = 16
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             op_valid_i,
   output logic             op_ready_o,
   input  xfer_kind_t       op_kind_i,
   input  reg_id_t          op_src_i,
   input  reg_id_t          op_dst_i,
   output logic             done_o,
   output logic             err_o,
   output reg_id_t          rf_addr_o,
   output logic             rf_we_o,
   output logic [RF_DW-1:0] rf_wdata_o,
   input  logic [RF_DW-1:0] rf_rdata_i
);

   typedef enum logic [2:0] {
      StIdle,
      StRdSrc,
      StWrDst,
      StErr
`ifdef XFER_FLAGS_EN
      ,
      StFlRd,
      StFlWr
`endif
   } state_e;

   state_e          state_q, state_d;
   xfer_kind_t      kind_q, kind_d;
   reg_id_t         src_q, src_d;
   reg_id_t         dst_q, dst_d;
   logic [BYTE-1:0] result_q, result_d;
`ifdef XFER_FLAGS_EN
   logic [BYTE-1:0] p_q, p_d;
`endif

   // Architectural data lives in the low byte; the rest of the read port is
   // deliberately ignored.
   logic unused_rdata_hi;
   assign unused_rdata_hi = ^rf_rdata_i[RF_DW-1:BYTE];

   // Gated by reset so decode never sees ready while the block is held in reset.
   assign op_ready_o = rstn_i && (state_q == StIdle);

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      src_d      = src_q;
      dst_d      = dst_q;
      result_d   = result_q;
`ifdef XFER_FLAGS_EN
      p_d        = p_q;
`endif
      done_o     = 1'b0;
      err_o      = 1'b0;
      rf_addr_o  = REG_A;
      rf_we_o    = 1'b0;
      rf_wdata_o = '0;

      unique case (state_q)
         StIdle: begin
            if (op_valid_i && op_ready_o) begin
               kind_d  = op_kind_i;
               src_d   = op_src_i;
               dst_d   = op_dst_i;
               state_d = xfer_legal(op_kind_i, op_src_i, op_dst_i) ? StRdSrc : StErr;
            end
         end

         StRdSrc: begin
            rf_addr_o = src_q;
            result_d  = xfer_alu(kind_q, rf_rdata_i[BYTE-1:0]);
            state_d   = StWrDst;
         end

         StWrDst: begin
            rf_addr_o  = dst_q;
            rf_we_o    = 1'b1;
            rf_wdata_o = RF_DW'(result_q);
`ifdef XFER_FLAGS_EN
            // TXS does not affect flags, so it completes here.
            if (dst_q != REG_SP) begin
               state_d = StFlRd;
            end else begin
               done_o  = 1'b1;
               state_d = StIdle;
            end
`else
            done_o  = 1'b1;
            state_d = StIdle;
`endif
         end

         StErr: begin
            done_o  = 1'b1;
            err_o   = 1'b1;
            state_d = StIdle;
         end

`ifdef XFER_FLAGS_EN
         StFlRd: begin
            rf_addr_o = REG_P;
            p_d       = rf_rdata_i[BYTE-1:0];
            state_d   = StFlWr;
         end

         StFlWr: begin
            rf_addr_o  = REG_P;
            rf_we_o    = 1'b1;
            rf_wdata_o = RF_DW'(p_with_nz(p_q, result_q));
            done_o     = 1'b1;
            state_d    = StIdle;
         end
`endif

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= StIdle;
         kind_q   <= XK_MOV;
         src_q    <= REG_A;
         dst_q    <= REG_A;
         result_q <= '0;
`ifdef XFER_FLAGS_EN
         p_q      <= '0;
`endif
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         result_q <= result_d;
`ifdef XFER_FLAGS_EN
         p_q      <= p_d;
`endif
      end
   end

   // Structural invariants of the handshake and completion signalling.
   a_err_with_done : assert property (@(posedge clk_i) disable iff (!rstn_i)
      err_o |-> done_o);
   a_done_pulse : assert property (@(posedge clk_i) disable iff (!rstn_i)
      done_o |=> !done_o);
   a_busy_not_ready : assert property (@(posedge clk_i) disable iff (!rstn_i)
      (rf_we_o || done_o) |-> !op_ready_o);
   a_no_err_write : assert property (@(posedge clk_i) disable iff (!rstn_i)
      err_o |-> !rf_we_o);

endmodule

// File: tb/tb_reg_xfer_seq.sv
module tb_reg_xfer_seq;
   import reg_xfer_seq_pkg::*;

   localparam int unsigned DW = 16;
`ifdef XFER_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic            clk_i = 1'b0;
   logic            rstn_i;
   logic            op_valid;
   logic            op_ready;
   xfer_kind_t      op_kind;
   reg_id_t         op_src;
   reg_id_t         op_dst;
   logic            done;
   logic            err;
   reg_id_t         rf_addr;
   logic            rf_we;
   logic [DW-1:0]   rf_wdata;
   logic [DW-1:0]   rf_rdata;

   always #5 clk_i = ~clk_i;

   reg_xfer_seq #(.RF_DW(DW)) dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .op_valid_i (op_valid),
      .op_ready_o (op_ready),
      .op_kind_i  (op_kind),
      .op_src_i   (op_src),
      .op_dst_i   (op_dst),
      .done_o     (done),
      .err_o      (err),
      .rf_addr_o  (rf_addr),
      .rf_we_o    (rf_we),
      .rf_wdata_o (rf_wdata),
      .rf_rdata_i (rf_rdata)
   );

   // Register file behind the DUT; upper read bits are junk on purpose.
   logic [7:0] rf      [0:7];
   logic [7:0] pl_vals [0:7];
   logic       pl_en;

   assign rf_rdata = {{(DW-BYTE){1'b1}}, rf[rf_addr]};

   always @(posedge clk_i) begin
      if (pl_en) begin
         for (int i = 0; i < 8; i++) rf[i] <= pl_vals[i];
      end else if (rf_we) begin
         rf[rf_addr] <= rf_wdata[7:0];
      end
   end

   // Expected register contents.
   logic [7:0] mdl [0:7];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Architectural effect of one op, straight from the 6502 rules.
   function automatic void model_apply(input xfer_kind_t k, input reg_id_t s, input reg_id_t d,
                                       output bit e, output int lat);
      int v;
      e = (s > 4) || (d > 4) || (s == REG_P) || (d == REG_P) || (k != XK_MOV && s != d);
      if (e) begin
         lat = 1;
         return;
      end
      v = int'(mdl[s]);
      if (k == XK_INC) v = v + 1;
      if (k == XK_DEC) v = v + 255;
      v = v % 256;
      mdl[d] = 8'(v);
      if (FLAGS && d != REG_SP) begin
         mdl[4] = (mdl[4] & 8'h7D) | (v >= 128 ? 8'h80 : 8'h00) | (v == 0 ? 8'h02 : 8'h00);
         lat = 4;
      end else begin
         lat = 2;
      end
   endfunction

   task automatic load_all(input logic [7:0] a, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] sp, input logic [7:0] p);
      @(negedge clk_i);
      pl_vals[0] = a;  pl_vals[1] = x;  pl_vals[2] = y;  pl_vals[3] = sp; pl_vals[4] = p;
      pl_vals[5] = 8'hEE; pl_vals[6] = 8'hEE; pl_vals[7] = 8'hEE;
      for (int i = 0; i < 8; i++) mdl[i] = pl_vals[i];
      pl_en = 1'b1;
      @(posedge clk_i);
      #1 pl_en = 1'b0;
   endtask

   task automatic check_rf(input string tag);
      for (int i = 0; i < 5; i++) check($sformatf("%s reg%0d", tag, i), 32'(rf[i]), 32'(mdl[i]));
   endtask

   task automatic wait_done(input string tag, input int lat, input bit e);
      int  cyc;
      bit  got_err;
      bit  we_seen;
      cyc = 0; got_err = 0; we_seen = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk_i);
         if (rf_we) begin
            we_seen = 1;
            check({tag, " wdata_hi"}, 32'(rf_wdata[DW-1:BYTE]), 32'h0);
         end
         if (done) begin
            cyc     = c;
            got_err = err;
            break;
         end
      end
      check({tag, " latency"}, 32'(cyc), 32'(lat));
      check({tag, " err"}, 32'(got_err), 32'(e));
      if (e) check({tag, " err_nowrite"}, 32'(we_seen), 32'h0);
      @(posedge clk_i);
      #1;
   endtask

   task automatic run_op(input xfer_kind_t k, input reg_id_t s, input reg_id_t d,
                         input string tag);
      bit e;
      int lat;
      model_apply(k, s, d, e, lat);
      @(negedge clk_i);
      check({tag, " ready"}, 32'(op_ready), 32'h1);
      op_kind = k; op_src = s; op_dst = d; op_valid = 1'b1;
      @(posedge clk_i);
      #1 op_valid = 1'b0;
      wait_done(tag, lat, e);
      check_rf(tag);
   endtask

   typedef struct {
      xfer_kind_t kind;
      reg_id_t    src;
      reg_id_t    dst;
      logic [7:0] src_val;
      logic [7:0] p_val;
      logic [7:0] exp_val;
      bit         exp_err;
      bit         exp_n;
      bit         exp_z;
   } vec_t;

   vec_t vecs [12];

   initial begin
      bit         e1, e2;
      int         l1, l2, acc, dones;
      logic [7:0] pre [0:4];
      logic [7:0] exp_p;
      xfer_kind_t rk;
      reg_id_t    rs, rd;

      vecs[0]  = '{XK_MOV, REG_X,  REG_A,  8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{XK_INC, REG_Y,  REG_Y,  8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{XK_DEC, REG_Y,  REG_Y,  8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{XK_MOV, REG_X,  REG_SP, 8'h80, 8'hFF, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{XK_MOV, REG_A,  REG_P,  8'h11, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{XK_INC, REG_X,  REG_Y,  8'h22, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{XK_MOV, reg_id_t'(3'd5), REG_A, 8'h33, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{XK_DEC, REG_A,  REG_A,  8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{XK_MOV, REG_SP, REG_X,  8'h7F, 8'h82, 8'h7F, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{XK_MOV, REG_A,  REG_Y,  8'hC3, 8'h00, 8'hC3, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{XK_INC, REG_X,  REG_X,  8'h7F, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{XK_MOV, REG_Y,  REG_A,  8'h00, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1};

      rstn_i = 1'b0; op_valid = 1'b0; pl_en = 1'b0;
      op_kind = XK_MOV; op_src = REG_A; op_dst = REG_A;

      // Reset values.
      #1;
      check("rst ready", 32'(op_ready), 32'h0);
      check("rst done", 32'(done), 32'h0);
      check("rst err", 32'(err), 32'h0);
      check("rst we", 32'(rf_we), 32'h0);
      check("rst addr", 32'(rf_addr), 32'(REG_A));
      check("rst wdata", 32'(rf_wdata), 32'h0);
      load_all(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      @(negedge clk_i);
      rstn_i = 1'b1;
      #1 check("rel ready", 32'(op_ready), 32'h1);

      // Directed table.
      for (int i = 0; i < 12; i++) begin
         pre[0] = 8'h10; pre[1] = 8'h20; pre[2] = 8'h30; pre[3] = 8'h40; pre[4] = vecs[i].p_val;
         if (vecs[i].src < REG_P) pre[vecs[i].src] = vecs[i].src_val;
         load_all(pre[0], pre[1], pre[2], pre[3], pre[4]);
         run_op(vecs[i].kind, vecs[i].src, vecs[i].dst, $sformatf("vec%0d", i));
         if (!vecs[i].exp_err)
            check($sformatf("vec%0d dstval", i), 32'(rf[vecs[i].dst]), 32'(vecs[i].exp_val));
         if (FLAGS && !vecs[i].exp_err && vecs[i].dst != REG_SP)
            exp_p = (vecs[i].p_val & 8'h7D) | {vecs[i].exp_n, 5'b0, vecs[i].exp_z, 1'b0};
         else
            exp_p = vecs[i].p_val;
         check($sformatf("vec%0d P", i), 32'(rf[4]), 32'(exp_p));
      end

      // Chained INC then DEC of Y across the wrap point.
      load_all(8'h01, 8'h02, 8'hFF, 8'h04, 8'h00);
      run_op(XK_INC, REG_Y, REG_Y, "chain inc");
      run_op(XK_DEC, REG_Y, REG_Y, "chain dec");
      check("chain Y", 32'(rf[2]), 32'hFF);

      // Back-to-back with op_valid held: second op accepted at E3 / E5.
      load_all(8'h00, 8'h5A, 8'hFF, 8'h40, 8'h00);
      model_apply(XK_MOV, REG_X, REG_A, e1, l1);
      model_apply(XK_INC, REG_Y, REG_Y, e2, l2);
      @(negedge clk_i);
      op_kind = XK_MOV; op_src = REG_X; op_dst = REG_A; op_valid = 1'b1;
      @(posedge clk_i);
      #1 op_kind = XK_INC; op_src = REG_Y; op_dst = REG_Y;
      acc = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk_i);
         if (op_ready) begin
            acc = k;
            break;
         end
      end
      check("b2b accept edge", 32'(acc), FLAGS ? 32'd5 : 32'd3);
      @(posedge clk_i);
      #1 op_valid = 1'b0;
      wait_done("b2b op2", l2, e2);
      check_rf("b2b");

      // A valid pulse while busy is dropped.
      load_all(8'h66, 8'h00, 8'h99, 8'h40, 8'h00);
      model_apply(XK_MOV, REG_A, REG_X, e1, l1);
      @(negedge clk_i);
      op_kind = XK_MOV; op_src = REG_A; op_dst = REG_X; op_valid = 1'b1;
      @(posedge clk_i);
      #1 op_valid = 1'b0;
      @(negedge clk_i);
      op_kind = XK_MOV; op_src = REG_Y; op_dst = REG_A; op_valid = 1'b1;
      @(posedge clk_i);
      #1 op_valid = 1'b0;
      wait_done("drop op", l1 - 1, e1);
      dones = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_i);
         if (done || rf_we) dones++;
      end
      check("drop no activity", 32'(dones), 32'h0);
      check_rf("drop");

      // Reset during WR_DST: abandoned with no write.
      load_all(8'h00, 8'h77, 8'h00, 8'h40, 8'h00);
      @(negedge clk_i);
      op_kind = XK_MOV; op_src = REG_X; op_dst = REG_A; op_valid = 1'b1;
      @(posedge clk_i);
      #1 op_valid = 1'b0;
      @(posedge clk_i);
      #2 rstn_i = 1'b0;
      #1;
      check("mid rst we", 32'(rf_we), 32'h0);
      check("mid rst done", 32'(done), 32'h0);
      check("mid rst err", 32'(err), 32'h0);
      check("mid rst addr", 32'(rf_addr), 32'(REG_A));
      check("mid rst wdata", 32'(rf_wdata), 32'h0);
      check("mid rst ready", 32'(op_ready), 32'h0);
      @(posedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;
      #1 check("mid rel ready", 32'(op_ready), 32'h1);
      check_rf("mid rst nowrite");
      run_op(XK_MOV, REG_X, REG_A, "post rst");

      // Randomized ops against the model.
      for (int n = 0; n < 80; n++) begin
         if (n % 8 == 0)
            load_all(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         rk = xfer_kind_t'(2'($urandom_range(0, 2)));
         rs = reg_id_t'(3'($urandom_range(0, 5)));
         if (rk != XK_MOV && ($urandom % 4) != 0) rd = rs;
         else rd = reg_id_t'(3'($urandom_range(0, 5)));
         run_op(rk, rs, rd, $sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
